// File: rtl/fft4_group_feeder_pkg.sv
// Shared types for the radix-4 group feeder: default widths, complex sample
// struct and the feeder state encoding.
package fft4_pkg;

    localparam int DATA_WIDTH_DEF  = 21;
    localparam int LABEL_WIDTH_DEF = 11;

    // One complex sample at the default component width
    typedef struct packed {
        logic signed [DATA_WIDTH_DEF-1:0] r;
        logic signed [DATA_WIDTH_DEF-1:0] i;
    } cplx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/fft4_group_feeder_if.sv
// Bundle of the feeder's control, serial input and group output signals.
// master = upstream driver / downstream consumer side, slave = the feeder.
interface fft4_group_feeder_if
    import fft4_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int LABEL_WIDTH = LABEL_WIDTH_DEF
);
    logic                          start;
    logic                          in_valid;
    logic                          in_ready;
    logic signed [DATA_WIDTH-1:0]  in_r;
    logic signed [DATA_WIDTH-1:0]  in_i;
    logic signed [DATA_WIDTH-1:0]  x0_r;
    logic signed [DATA_WIDTH-1:0]  x0_i;
    logic signed [DATA_WIDTH-1:0]  x1_r;
    logic signed [DATA_WIDTH-1:0]  x1_i;
    logic signed [DATA_WIDTH-1:0]  x2_r;
    logic signed [DATA_WIDTH-1:0]  x2_i;
    logic signed [DATA_WIDTH-1:0]  x3_r;
    logic signed [DATA_WIDTH-1:0]  x3_i;
    logic [LABEL_WIDTH-1:0]        lable;
    logic                          valid;
    logic                          busy;
    logic                          done;

    modport master (
        output start, in_valid, in_r, in_i,
        input  in_ready, x0_r, x0_i, x1_r, x1_i, x2_r, x2_i, x3_r, x3_i,
        input  lable, valid, busy, done
    );

    modport slave (
        input  start, in_valid, in_r, in_i,
        output in_ready, x0_r, x0_i, x1_r, x1_i, x2_r, x2_i, x3_r, x3_i,
        output lable, valid, busy, done
    );

endinterface

// File: rtl/fft4_group_feeder_bank_ram.sv
// One sample bank: simple dual-port RAM, one write port and a synchronous
// one-cycle read port. Contents are never reset.
module fft4_bank_ram #(
    parameter int DATA_WIDTH = 21,
    parameter int M_POINTS   = 2048,
    parameter int AW         = 11
) (
    input  logic                    clk,
    input  logic                    i_we,
    input  logic [AW-1:0]           i_waddr,
    input  logic [2*DATA_WIDTH-1:0] i_wdata,
    input  logic                    i_re,
    input  logic [AW-1:0]           i_raddr,
    output logic [2*DATA_WIDTH-1:0] o_rdata
);

    logic [2*DATA_WIDTH-1:0] r_mem [M_POINTS];
    logic [2*DATA_WIDTH-1:0] r_rdata;

    // Write port: store the accepted sample
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port: registered read, data valid the cycle after i_re
    always_ff @(posedge clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/fft4_group_feeder.sv
// Radix-4 DIT group feeder: fills four banks from a serial stream, then
// drains one group {bank0..bank3 @ m} per cycle towards the merge stage.
module fft4_group_feeder
    import fft4_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int LABEL_WIDTH = LABEL_WIDTH_DEF,
    parameter int M_POINTS    = 2048
) (
    input  logic               clk,
    input  logic               rst_n,
    fft4_group_feeder_if.slave bus
);

    localparam int            AW        = (M_POINTS > 1) ? $clog2(M_POINTS) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(M_POINTS - 1);

    state_t                        r_state;
    logic [1:0]                    r_wr_bank;
    logic [AW-1:0]                 r_wr_addr;
    logic [AW-1:0]                 r_rd_addr;
    logic                          r_rd_vld_p1;
    logic [AW-1:0]                 r_rd_lbl_p1;
    logic                          r_rd_last_p1;
    logic                          r_valid;
    logic                          r_done;
    logic [LABEL_WIDTH-1:0]        r_lable;
    logic signed [DATA_WIDTH-1:0]  r_xr [4];
    logic signed [DATA_WIDTH-1:0]  r_xi [4];

    logic                          w_accept;
    logic                          w_rd_en;
    logic [2*DATA_WIDTH-1:0]       w_wdata;
    logic [2*DATA_WIDTH-1:0]       w_rdata [4];

    assign w_accept = bus.in_valid && (r_state == FILL);
    assign w_rd_en  = (r_state == DRAIN);
    assign w_wdata  = {bus.in_r, bus.in_i};

    // Four banks share write data and read address; only the bank selected
    // by the write counter's bank index takes the sample.
    for (genvar k = 0; k < 4; k++) begin : g_bank
        fft4_bank_ram #(
            .DATA_WIDTH (DATA_WIDTH),
            .M_POINTS   (M_POINTS),
            .AW         (AW)
        ) u_bank (
            .clk     (clk),
            .i_we    (w_accept && (r_wr_bank == 2'(k))),
            .i_waddr (r_wr_addr),
            .i_wdata (w_wdata),
            .i_re    (w_rd_en),
            .i_raddr (r_rd_addr),
            .o_rdata (w_rdata[k])
        );
    end

    // FSM with write counter (bank:addr) and drain read-address counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_wr_bank <= '0;
            r_wr_addr <= '0;
            r_rd_addr <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state <= FILL;
                    end
                end
                FILL: begin
                    if (w_accept) begin
                        if (r_wr_addr == LAST_ADDR) begin
                            r_wr_addr <= '0;
                            if (r_wr_bank == 2'd3) begin
                                r_wr_bank <= '0;
                                r_state   <= DRAIN;
                            end else begin
                                r_wr_bank <= r_wr_bank + 2'd1;
                            end
                        end else begin
                            r_wr_addr <= r_wr_addr + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (r_rd_addr == LAST_ADDR) begin
                        r_rd_addr <= '0;
                        r_state   <= IDLE;
                    end else begin
                        r_rd_addr <= r_rd_addr + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Stage p1: track the read issued this cycle alongside the RAM latency
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_vld_p1  <= 1'b0;
            r_rd_lbl_p1  <= '0;
            r_rd_last_p1 <= 1'b0;
        end else begin
            r_rd_vld_p1  <= w_rd_en;
            r_rd_lbl_p1  <= r_rd_addr;
            r_rd_last_p1 <= w_rd_en && (r_rd_addr == LAST_ADDR);
        end
    end

    // Output stage: capture RAM data with its label; hold while not valid
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_lable <= '0;
            for (int k = 0; k < 4; k++) begin
                r_xr[k] <= '0;
                r_xi[k] <= '0;
            end
        end else begin
            r_valid <= r_rd_vld_p1;
            r_done  <= r_rd_vld_p1 && r_rd_last_p1;
            if (r_rd_vld_p1) begin
                r_lable <= LABEL_WIDTH'(r_rd_lbl_p1);
                for (int k = 0; k < 4; k++) begin
                    r_xr[k] <= $signed(w_rdata[k][2*DATA_WIDTH-1:DATA_WIDTH]);
                    r_xi[k] <= $signed(w_rdata[k][DATA_WIDTH-1:0]);
                end
            end
        end
    end

    assign bus.in_ready = (r_state == FILL);
    assign bus.busy     = (r_state != IDLE);
    assign bus.valid    = r_valid;
    assign bus.done     = r_done;
    assign bus.lable    = r_lable;
    assign bus.x0_r     = r_xr[0];
    assign bus.x0_i     = r_xi[0];
    assign bus.x1_r     = r_xr[1];
    assign bus.x1_i     = r_xi[1];
    assign bus.x2_r     = r_xr[2];
    assign bus.x2_i     = r_xi[2];
    assign bus.x3_r     = r_xr[3];
    assign bus.x3_i     = r_xi[3];

endmodule

// File: doc/fft4_group_feeder.md
# fft4_group_feeder

Upstream source for the four-input twiddle multiply/merge stage of the radix-4 DIT FFT. The block collects the serial output of four length-M sub-FFTs into four sample banks. It then issues one group of four complex samples per cycle: x0..x3 taken at bank address m, with `lable` = m and a `valid` strobe. This produces exactly the `valid`/`lable`/x0..x3 stream the merge stage consumes, which has no backpressure.

## Interface
Parameters:
- DATA_WIDTH, 21, signed width of each real and imaginary component.
- LABEL_WIDTH, 11, width of `lable`.
- M_POINTS, 2048, sub-FFT length (power of two, ≤ 2^LABEL_WIDTH); bank depth.

Ports:
- clk  in  1  single clock; one clock domain, all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  pulse; begins a fill when the FSM is in IDLE.
- in_valid  in  1  serial sample present.
- in_ready  out  1  block accepts a sample; a transfer occurs when in_valid & in_ready.
- in_r, in_i  in  DATA_WIDTH  serial sample, real and imaginary.
- x0_r, x0_i … x3_r, x3_i  out  DATA_WIDTH  group outputs, registered.
- lable  out  LABEL_WIDTH  group index m, zero-extended.
- valid  out  1  group outputs valid this cycle.
- busy  out  1  FSM not in IDLE.
- done  out  1  one-cycle pulse, coincident with the last valid group.

## Operation
- FSM states:
  - IDLE: in_ready=0. Goes to FILL on start.
  - FILL: in_ready=1. Goes to DRAIN on the 4·M_POINTS-th accepted sample.
  - DRAIN: issues read address rd_addr 0..M_POINTS-1, one per cycle. Goes to IDLE after issuing M_POINTS-1.
- Fill mapping:
  - Accepted sample n (0..4M-1) is written to bank n / M_POINTS, address n mod M_POINTS.
  - The write counter is a bank index (2 b) plus an address of $clog2(M_POINTS) bits, wrapping the address into the bank increment.
- Drain:
  - All four banks are read at rd_addr simultaneously. Bank k data goes to xk_r/xk_i.
  - The registered read data appears one cycle later, with lable=rd_addr and valid=1.
- Data passes bit-exact. There is no arithmetic, rounding or sign handling.
- start is ignored in FILL and DRAIN. in_valid is ignored when in_ready=0.
- Gaps in in_valid during FILL only stretch the fill; bank mapping is unchanged.
- The DRAIN stream cannot stall: valid is high for exactly M_POINTS consecutive cycles.
- start in the IDLE cycle that carries done is accepted. The last read has already been issued, so there is no bank hazard.
- rst_n=0 at any time, including mid-FILL or mid-DRAIN, clears on the next edge:
  - the FSM returns to IDLE;
  - all counters are cleared;
  - all outputs take their reset values;
  - bank contents are not cleared.

## Timing
- Reset values: in_ready=0, valid=0, done=0, busy=0, lable=0, all x*=0.
- in_ready and busy decode the registered state.
- The edge that accepts the last sample moves the FSM to DRAIN, so in_ready is low in the next cycle.
- Latency:
  - Read of address 0 at the first DRAIN edge.
  - valid first high 2 cycles after the last-accept edge.
  - Last group (lable=M-1) 2+M-1 cycles after that edge.
- done is high in the same cycle as lable=M-1 with valid=1. The FSM is IDLE in that cycle.
- While valid=0, the x* and lable outputs hold their last values.

## Structure
- Shared package `fft4_pkg`:
  - DATA_WIDTH and LABEL_WIDTH defaults;
  - `cplx_t` packed struct {r, i};
  - state enum {IDLE, FILL, DRAIN}.
- Sub-module `fft4_bank_ram`: simple dual-port RAM, one write port, synchronous one-cycle read, depth M_POINTS, 2·DATA_WIDTH wide. The feeder instantiates it four times; bank k write enable = accept & (wr_bank==k).
- The top level holds the FSM, write and read counters, the valid/lable/done output registers, and the x* output assignment from the RAM read ports.

## Test plan
Run with M_POINTS=4 unless noted.
- Basic fill/drain: start, then 16 back-to-back samples in_r=n, in_i=−n.
  - in_ready low after the 16th accept.
  - valid for 4 cycles starting 2 cycles later; lable 0..3.
  - Each group: x0_r=m, x1_r=4+m, x2_r=8+m, x3_r=12+m, and every _i = −(corresponding _r).
  - done with lable=3.
- Bubbly input: in_valid high every other cycle → outputs identical to the basic case; the fill takes 32 cycles.
- Ignored controls:
  - in_valid high in IDLE → in_ready=0 and nothing written.
  - start pulsed mid-FILL and mid-DRAIN → no effect; group contents unchanged.
- Reset mid-DRAIN: rst_n=0 in the cycle after lable=1 → next cycle valid=0, busy=0, done=0, x*=0, lable=0. A new start plus 16 fresh samples yields correct groups.
- Back-to-back runs: start asserted in the done cycle → in_ready=1 in the next cycle; the second run's groups reflect only the new samples.
- Extremes:
  - Component values 0x0FFFFF and 0x100000 (21-bit max/min) pass bit-exact in every xk slot.
  - With M_POINTS=2048: lable reaches 2047 and done fires exactly once.
